// File: rtl/pipeout_sample_buffer_pkg.sv
// Shared types and constants for the pipe-out sample capture buffer.
package pipeout_sample_buffer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_e;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_DEPTH_LOG2 = 10;

    localparam int CAPLEN_W = 16;
    localparam int DECIM_W  = 8;
    // One extra bit so a full 2**16-word capture length is representable
    localparam int REM_W    = CAPLEN_W + 1;

    localparam logic [CAPLEN_W-1:0] CAPLEN_FULL = '0;

    function automatic logic [REM_W-1:0] cap_len_map(
        input logic [CAPLEN_W-1:0] len,
        input int unsigned         dlog2
    );
        logic [REM_W-1:0] full_len;
        full_len = REM_W'(1) << dlog2;
        if (len == CAPLEN_FULL) return full_len;
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/pipeout_sample_buffer_sample_fifo_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module sample_fifo_mem
    import pipeout_sample_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/pipeout_sample_buffer.sv
// Armed sample capture into a FWFT FIFO drained by a pipe-out reader.
// Optional decimation is built when SAMPLE_BUFFER_DECIM_EN is defined.
module pipeout_sample_buffer
    import pipeout_sample_buffer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     arm,
    input  logic [CAPLEN_W-1:0]      capture_len,
    input  logic [DECIM_W-1:0]       decim,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [DEPTH_LOG2:0]      count,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2**DEPTH_LOG2);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pend_q, pend_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic             sample_evt;
    logic             take;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;
    logic             last;
    logic [CNT_W-1:0] fill;
    logic [DATA_W-1:0] ram_rdata;

    assign sample_evt = (state_q == ST_CAPTURE) && sample_valid && !arm;

`ifdef SAMPLE_BUFFER_DECIM_EN
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic [DECIM_W-1:0] dreload_q, dreload_d;

    assign take = sample_evt && (dcnt_q == '0);

    always_comb begin
        dcnt_d    = dcnt_q;
        dreload_d = dreload_q;
        if (arm) begin
            dcnt_d    = '0;
            dreload_d = decim;
        end else if (sample_evt) begin
            dcnt_d = (dcnt_q == '0) ? dreload_q : dcnt_q - DECIM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q    <= '0;
            dreload_q <= '0;
        end else begin
            dcnt_q    <= dcnt_d;
            dreload_q <= dreload_d;
        end
    end
`else
    logic unused_decim;
    assign unused_decim = ^decim;
    assign take = sample_evt;
`endif

    // A push becomes visible one edge after it is written, so the
    // in-flight word counts toward occupancy when judging fullness.
    assign fill = count_q + CNT_W'(pend_q);
    assign full = (fill == DEPTH_C);
    assign pop  = rd_en && !arm && (count_q != '0);
    assign push = take && (!full || pop);
    assign drop = take && full && !pop;
    assign last = take && (rem_q == REM_W'(1));

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        count_d  = count_q + CNT_W'(pend_q) - CNT_W'(pop);
        pend_d   = push;
        rem_d    = take ? rem_q - REM_W'(1) : rem_q;
        ovf_d    = ovf_q | drop;
        done_d   = (state_q == ST_CAPTURE) && last;
        if (arm) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pend_d   = 1'b0;
            rem_d    = cap_len_map(capture_len, DEPTH_LOG2);
            ovf_d    = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (arm)       state_d = ST_CAPTURE;
                else if (last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Reading the post-pop address keeps the registered port on the head.
    sample_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_in),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        busy     = (state_q == ST_CAPTURE);
        done     = done_q;
        overflow = ovf_q;
        count    = count_q;
        rd_data  = (count_q == '0) ? '0 : ram_rdata;
    end

endmodule

// File: tb/tb_pipeout_sample_buffer.sv
// Scoreboard bench for pipeout_sample_buffer at DEPTH_LOG2=2.
module tb_pipeout_sample_buffer;

    localparam int DW = 16;
    localparam int DL = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] sample_in;
    logic                 sample_valid;
    logic                 arm;
    logic [15:0]          capture_len;
    logic [7:0]           decim;
    logic                 rd_en;
    logic [DW-1:0]        rd_data;
    logic [DL:0]          count;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipeout_sample_buffer #(
        .DATA_W     (DW),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .capture_len  (capture_len),
        .decim        (decim),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    // Monitor: every accepted pop is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && rd_en && !arm && count != '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %0d, queue empty", rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL pop_data: got %0d, want %0d", rd_data, e);
                end
            end
        end
        if (!reset && done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic send(input int v);
        sample_in    = DW'(v);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm(input int len, input int dc);
        capture_len = 16'(len);
        decim       = 8'(dc);
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
    endtask

    task automatic read_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    task automatic expect_push(input int v);
        exp_q.push_back(DW'(v));
    endtask

    initial begin
        int d0;
        reset        = 1'b1;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        rd_en        = 1'b0;
        capture_len  = '0;
        decim        = '0;
        repeat (3) tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        tick();

        // Basic capture of four samples
        d0 = done_cnt;
        do_arm(4, 0);
        chk("arm_busy", 32'(busy), 1);
        for (int v = 1; v <= 4; v++) begin
            expect_push(v);
            send(v);
        end
        chk("basic_done", 32'(done), 1);
        chk("basic_busy", 32'(busy), 0);
        tick();
        chk("basic_done_drop", 32'(done), 0);
        chk("basic_count", 32'(count), 4);
        read_n(4);
        chk("basic_empty_count", 32'(count), 0);
        chk("basic_empty_data", 32'(rd_data), 0);
        chk("basic_done_once", 32'(done_cnt - d0), 1);

        // Decimation (or its absence in the default build)
        d0 = done_cnt;
        do_arm(3, 2);
`ifdef SAMPLE_BUFFER_DECIM_EN
        expect_push(0);
        expect_push(3);
        expect_push(6);
`else
        expect_push(0);
        expect_push(1);
        expect_push(2);
`endif
        for (int v = 0; v <= 8; v++) begin
            sample_in    = DW'(v);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        tick();
        chk("decim_count", 32'(count), 3);
        chk("decim_done_once", 32'(done_cnt - d0), 1);
        read_n(3);

        // Full FIFO with simultaneous push and pop
        d0 = done_cnt;
        do_arm(8, 0);
        for (int v = 41; v <= 44; v++) begin
            expect_push(v);
            send(v);
        end
        tick();
        chk("full_count", 32'(count), 4);
        rd_en = 1'b1;
        for (int v = 45; v <= 47; v++) begin
            expect_push(v);
            sample_in    = DW'(v);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        rd_en        = 1'b0;
        tick();
        chk("pp_count", 32'(count), 4);
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_busy", 32'(busy), 1);
        expect_push(48);
        rd_en        = 1'b1;
        sample_in    = DW'(48);
        sample_valid = 1'b1;
        tick();
        rd_en        = 1'b0;
        sample_valid = 1'b0;
        chk("pp_done", 32'(done), 1);
        tick();
        chk("pp_count_end", 32'(count), 4);
        chk("pp_overflow_end", 32'(overflow), 0);
        read_n(4);
        chk("pp_done_once", 32'(done_cnt - d0), 1);

        // Simultaneous push and pop on an empty FIFO
        do_arm(2, 0);
        expect_push(51);
        expect_push(52);
        rd_en        = 1'b1;
        sample_in    = DW'(51);
        sample_valid = 1'b1;
        tick();
        rd_en        = 1'b0;
        sample_valid = 1'b0;
        tick();
        chk("empty_pp_count", 32'(count), 1);
        chk("empty_pp_head", 32'(rd_data), 51);
        send(52);
        chk("empty_pp_done", 32'(done), 1);
        tick();
        read_n(2);

        // Overflow with capture_len beyond the depth
        d0 = done_cnt;
        do_arm(6, 0);
        for (int v = 31; v <= 36; v++) begin
            if (v <= 34) expect_push(v);
            send(v);
        end
        chk("ovf_done", 32'(done), 1);
        chk("ovf_flag", 32'(overflow), 1);
        tick();
        chk("ovf_count", 32'(count), 4);
        read_n(4);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_done_once", 32'(done_cnt - d0), 1);

        // capture_len 0 means full depth
        do_arm(0, 0);
        for (int v = 61; v <= 63; v++) begin
            expect_push(v);
            send(v);
        end
        chk("len0_busy", 32'(busy), 1);
        expect_push(64);
        send(64);
        chk("len0_done", 32'(done), 1);
        tick();
        read_n(4);

        // Re-arm mid-capture flushes and wins over pop/sample
        do_arm(8, 0);
        chk("rearm_ovf_clear", 32'(overflow), 0);
        for (int v = 71; v <= 73; v++) send(v);
        tick();
        chk("mid_count", 32'(count), 3);
        rd_en        = 1'b1;
        sample_in    = DW'(74);
        sample_valid = 1'b1;
        do_arm(2, 0);
        rd_en        = 1'b0;
        sample_valid = 1'b0;
        chk("rearm_count", 32'(count), 0);
        chk("rearm_busy", 32'(busy), 1);
        tick();
        chk("rearm_discard", 32'(count), 0);
        expect_push(81);
        expect_push(82);
        send(81);
        send(82);
        tick();
        chk("rearm_new_count", 32'(count), 2);
        read_n(2);

        // Reset mid-capture aborts without done
        do_arm(8, 0);
        send(91);
        send(92);
        d0    = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_data", 32'(rd_data), 0);
        repeat (3) tick();
        chk("rst_mid_no_done", 32'(done_cnt - d0), 0);

        // Reset overrides arm; IDLE ignores samples
        reset       = 1'b1;
        arm         = 1'b1;
        capture_len = 16'd4;
        tick();
        reset = 1'b0;
        arm   = 1'b0;
        chk("rst_over_arm", 32'(busy), 0);
        send(99);
        tick();
        chk("idle_ignore", 32'(count), 0);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeout_sample_buffer.md
PIPEOUT_SAMPLE_BUFFER -- requirements
Module: pipeout_sample_buffer

Interface
REQ-001 Parameter DATA_W, default 16, sample and read word width.
REQ-002 Parameter DEPTH_LOG2, default 10, FIFO depth is 2**DEPTH_LOG2 words.
REQ-003 Port clk  input  1  sole clock; every port is synchronous to clk.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port sample_in  input  DATA_W  signed sample from the synthesis datapath.
REQ-006 Port sample_valid  input  1  sample_in is valid this cycle.
REQ-007 Port arm  input  1  single-cycle pulse; flush the FIFO and start a capture.
REQ-008 Port capture_len  input  16  number of samples to store; 0 means 2**DEPTH_LOG2; sampled on arm.
REQ-009 Port decim  input  8  store one of every decim+1 valid samples; sampled on arm.
REQ-010 Port rd_en  input  1  pipe-out read strobe; pops one word.
REQ-011 Port rd_data  output  DATA_W  head of FIFO (first-word-fall-through).
REQ-012 Port count  output  DEPTH_LOG2+1  words currently held.
REQ-013 Port busy  output  1  high while in CAPTURE.
REQ-014 Port done  output  1  one-cycle pulse at the end of a capture.
REQ-015 Port overflow  output  1  sticky; a sample was dropped because the FIFO was full.

Function
REQ-016 States: IDLE and CAPTURE; IDLE ignores sample_valid.
REQ-017 arm in any state: count:=0, overflow:=0, remaining:=capture_len (0 maps to 2**DEPTH_LOG2), decim counter:=0, next state CAPTURE.
REQ-018 In CAPTURE, on sample_valid with decim counter 0: store sample_in if not full, decrement remaining, reload decim counter with decim; with counter nonzero: decrement counter only.
REQ-019 Write when full (and no simultaneous pop): sample dropped, overflow:=1, remaining still decremented.
REQ-020 When remaining reaches 0: next cycle done=1 for exactly one cycle, busy=0, state IDLE.
REQ-021 A sample accepted at edge k appears in count (and at rd_data if it is the head) after edge k+1.
REQ-022 rd_en with count>0: pop, next word at rd_data after the following edge; rd_en with count=0: ignored.
REQ-023 rd_data is 0 when count=0.
REQ-024 Simultaneous push and pop when full: both take effect, count unchanged, no overflow.
REQ-025 Simultaneous push and pop when empty: push accepted, pop ignored.
REQ-026 arm coincident with rd_en or sample_valid: arm wins; pop and sample are discarded.
REQ-027 Read and write pointers wrap modulo 2**DEPTH_LOG2; count never exceeds 2**DEPTH_LOG2.

Reset
REQ-028 reset: state IDLE, count=0, rd_data=0, busy=0, done=0, overflow=0, pointers 0; memory contents are not cleared.
REQ-029 reset mid-capture aborts the capture with no done pulse; reset overrides arm.

Configuration
REQ-030 Macro SAMPLE_BUFFER_DECIM_EN defined: decimation per REQ-009 and REQ-018.
REQ-031 Macro undefined: decim is ignored and no decim counter exists; every valid sample is stored.

Structure
REQ-032 Shared package holds the state enum, the default DATA_W and DEPTH_LOG2 values, and the capture_len-zero-means-full constant.
REQ-033 One sub-module, sample_fifo_mem: simple dual-port RAM with one write port and one registered read port.

Verification
REQ-034 arm with capture_len=4, decim=0, then 4 valid samples 1,2,3,4 -> done pulse once, count=4, four rd_en return 1,2,3,4, then rd_data=0.
REQ-035 With SAMPLE_BUFFER_DECIM_EN, decim=2, capture_len=3, 9 valid samples 0..8 -> stored 0,3,6; done once.
REQ-036 DEPTH_LOG2=2, capture_len=6, no reads -> count=4, overflow=1, done after the sixth sample, reads return the first 4 samples.
REQ-037 Full FIFO with simultaneous rd_en and sample_valid -> count stays 4, overflow stays 0, order preserved.
REQ-038 arm mid-capture with count=3 -> count=0, overflow cleared, new capture starts; reset mid-capture -> IDLE, no done.
